// File: rtl/mem_bus_pkg.sv
// Shared definitions for the L1-to-memory bus arbiter: FSM states, client indices,
// tag read bit and line length.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD_BEATS,
    WR_BEATS,
    DONE
  } arb_state_t;

  localparam int ICACHE         = 0;
  localparam int DCACHE         = 1;
  localparam int TAG_READ_BIT   = 12;
  localparam int BEATS_PER_LINE = 8;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational 2-way grant. Round-robin on ties by default; with ARB_DCACHE_PRIORITY_EN
// defined the dcache wins every tie and rr_last is ignored.
module arb_rr_picker
  import mem_bus_pkg::*;
(
  input  logic [1:0] reqcyc,
  input  logic       rr_last,
  output logic       grant
);

`ifdef ARB_DCACHE_PRIORITY_EN
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  always_comb begin
    grant = reqcyc[DCACHE] ? 1'(DCACHE) : 1'(ICACHE);
  end
`else
  // On a tie the client that did not own the bus last time wins.
  always_comb begin
    if (reqcyc[ICACHE] && reqcyc[DCACHE]) grant = ~rr_last;
    else                                   grant = reqcyc[DCACHE] ? 1'(DCACHE) : 1'(ICACHE);
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache 8-beat line fills and writebacks onto one memory bus.
// Optional build macro: ARB_DCACHE_PRIORITY_EN (fixed dcache priority instead of round-robin).
module cache_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int TAGWIDTH = TAG_READ_BIT + 1,
  parameter int BEATS    = BEATS_PER_LINE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          c_reqcyc,
  input  logic [WORDSIZE-1:0] c_req [2],
  input  logic [TAGWIDTH-1:0] c_reqtag [2],
  output logic [1:0]          c_reqack,
  output logic [1:0]          c_respcyc,
  output logic [WORDSIZE-1:0] c_resp,
  output logic [TAGWIDTH-1:0] c_resptag,
  input  logic [1:0]          c_respack,
  output logic                m_reqcyc,
  output logic [WORDSIZE-1:0] m_req,
  output logic [TAGWIDTH-1:0] m_reqtag,
  input  logic                m_reqack,
  input  logic                m_respcyc,
  input  logic [WORDSIZE-1:0] m_resp,
  input  logic [TAGWIDTH-1:0] m_resptag,
  output logic                m_respack
);

  localparam int BEAT_W   = $clog2(BEATS) + 1;
  localparam int READ_BIT = TAGWIDTH - 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  arb_state_t          state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_last_q, rr_last_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                grant;

  logic [1:0]          c_reqack_d, c_respcyc_d;
  logic [WORDSIZE-1:0] c_resp_d, m_req_d;
  logic [TAGWIDTH-1:0] c_resptag_d, m_reqtag_d;
  logic                m_reqcyc_d, m_respack_d;

  arb_rr_picker u_picker (
    .reqcyc  (c_reqcyc),
    .rr_last (rr_last_q),
    .grant   (grant)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    beat_d      = beat_q;
    m_reqcyc_d  = m_reqcyc;
    m_req_d     = m_req;
    m_reqtag_d  = m_reqtag;
    c_reqack_d  = '0;
    c_respcyc_d = c_respcyc;
    c_resp_d    = c_resp;
    c_resptag_d = c_resptag;
    m_respack_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|c_reqcyc) begin
          owner_d    = grant;
          m_req_d    = c_req[grant];
          m_reqtag_d = c_reqtag[grant];
          m_reqcyc_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (m_reqack) begin
          m_reqcyc_d          = 1'b0;
          c_reqack_d[owner_q] = 1'b1;
          beat_d              = '0;
          state_d             = m_reqtag[READ_BIT] ? RD_BEATS : WR_BEATS;
        end
      end
      RD_BEATS: begin
        // The m_respack guard stops the beat just acked from being captured twice.
        if (c_respcyc[owner_q]) begin
          if (c_respack[owner_q]) begin
            c_respcyc_d = '0;
            m_respack_d = 1'b1;
            beat_d      = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) state_d = DONE;
          end
        end else if (m_respcyc && !m_respack) begin
          c_resp_d             = m_resp;
          c_resptag_d          = m_resptag;
          c_respcyc_d[owner_q] = 1'b1;
        end
      end
      WR_BEATS: begin
        // A beat is only latched once the client has seen the previous ack pulse.
        if (m_reqcyc) begin
          if (m_reqack) begin
            m_reqcyc_d          = 1'b0;
            c_reqack_d[owner_q] = 1'b1;
            beat_d              = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) state_d = DONE;
          end else if (!c_reqcyc[owner_q]) begin
            m_reqcyc_d = 1'b0;
          end
        end else if (c_reqcyc[owner_q] && !c_reqack[owner_q]) begin
          m_reqcyc_d = 1'b1;
          m_req_d    = c_req[owner_q];
          m_reqtag_d = c_reqtag[owner_q];
        end
      end
      DONE: begin
        m_reqcyc_d  = 1'b0;
        c_respcyc_d = '0;
        rr_last_d   = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      beat_q    <= '0;
      m_reqcyc  <= 1'b0;
      m_req     <= '0;
      m_reqtag  <= '0;
      c_reqack  <= '0;
      c_respcyc <= '0;
      c_resp    <= '0;
      c_resptag <= '0;
      m_respack <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
      m_reqcyc  <= m_reqcyc_d;
      m_req     <= m_req_d;
      m_reqtag  <= m_reqtag_d;
      c_reqack  <= c_reqack_d;
      c_respcyc <= c_respcyc_d;
      c_resp    <= c_resp_d;
      c_resptag <= c_resptag_d;
      m_respack <= m_respack_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed cache transactions, bus and client
// monitors pop expected headers/beats from queues.
module tb_cache_mem_arbiter;

  typedef logic [76:0] bw_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  c_reqcyc;
  logic        tb_cyc [2];
  logic [63:0] c_req [2];
  logic [12:0] c_reqtag [2];
  logic [1:0]  c_reqack, c_respcyc, c_respack;
  logic [63:0] c_resp, m_req, m_resp;
  logic [12:0] c_resptag, m_reqtag, m_resptag;
  logic        m_reqcyc, m_reqack, m_respcyc, m_respack;

  assign c_reqcyc = {tb_cyc[1], tb_cyc[0]};

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_reqcyc(c_reqcyc), .c_req(c_req), .c_reqtag(c_reqtag), .c_reqack(c_reqack),
    .c_respcyc(c_respcyc), .c_resp(c_resp), .c_resptag(c_resptag), .c_respack(c_respack),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
    .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack)
  );

  int checks = 0;
  int errors = 0;

  bw_t exp_bus [$];
  bw_t exp_resp [2][$];
  bw_t rd_q [$];
  int  rsp_cnt [2];
  int  n_reqack [2];
  int  n_respack = 0;
  int  hold_idx = 0, hold_beat = 0, hold_left = 0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Memory bus model: acks every request on the next edge, returns 8 beats per read header.
  always @(negedge clk) begin
    if (reset) begin
      m_reqack  = 1'b0;
      m_respcyc = 1'b0;
      rd_q.delete();
    end else begin
      if (m_reqack) m_reqack = 1'b0;
      else if (m_reqcyc) begin
        check("bus_req_expected", 192'(exp_bus.size() != 0), 192'(1));
        if (exp_bus.size() != 0) check("bus_req", 192'({m_req, m_reqtag}), 192'(exp_bus.pop_front()));
        m_reqack = 1'b1;
        if (m_reqtag[12])
          for (int k = 0; k < 8; k++) rd_q.push_back({m_req[31:0], 32'(k), m_reqtag});
      end
      if (m_respack) begin
        n_respack++;
        if (m_respcyc && rd_q.size() != 0) void'(rd_q.pop_front());
      end
      m_respcyc = (rd_q.size() != 0);
      if (rd_q.size() != 0) {m_resp, m_resptag} = rd_q[0];
      for (int i = 0; i < 2; i++) if (c_reqack[i]) n_reqack[i]++;
    end
  end

  // Client response monitors, with an optional hold on one beat.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) c_respack[i] = 1'b0;
      else if (c_respack[i]) c_respack[i] = 1'b0;
      else if (c_respcyc[i]) begin
        check("resp_expected", 192'(exp_resp[i].size() != 0), 192'(1));
        if (exp_resp[i].size() != 0) begin
          if (i == hold_idx && rsp_cnt[i] == hold_beat && hold_left > 0) begin
            check("hold_resp_stable", 192'({c_resp, c_resptag}), 192'(exp_resp[i][0]));
            check("hold_no_respack", 192'(m_respack), 192'(0));
            hold_left--;
          end else begin
            check("resp_beat", 192'({c_resp, c_resptag}), 192'(exp_resp[i].pop_front()));
            c_respack[i] = 1'b1;
            rsp_cnt[i]++;
          end
        end
      end
    end
  end

  task automatic wait_ack(input int i);
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (c_reqack[i]) begin ok = 1'b1; break; end
    end
    check("reqack_timeout", 192'(ok), 192'(1));
  endtask

  task automatic client_read(input int i, input logic [63:0] addr, input logic [12:0] tag);
    @(negedge clk);
    tb_cyc[i] = 1'b1; c_req[i] = addr; c_reqtag[i] = tag;
    wait_ack(i);
    tb_cyc[i] = 1'b0;
  endtask

  task automatic client_write(input int i, input logic [63:0] addr, input logic [12:0] tag,
                              input logic [63:0] base, input int stall_beat);
    @(negedge clk);
    tb_cyc[i] = 1'b1; c_req[i] = addr; c_reqtag[i] = tag;
    wait_ack(i);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_beat) begin
        tb_cyc[i] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_m_reqcyc", 192'(m_reqcyc), 192'(0));
        end
        tb_cyc[i] = 1'b1;
      end
      c_req[i] = base + 64'(k);
      wait_ack(i);
    end
    tb_cyc[i] = 1'b0;
  endtask

  task automatic push_read(input int i, input logic [63:0] addr, input logic [12:0] tag);
    exp_bus.push_back({addr, tag});
    for (int k = 0; k < 8; k++) exp_resp[i].push_back({addr[31:0], 32'(k), tag});
  endtask

  task automatic push_write(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base);
    exp_bus.push_back({addr, tag});
    for (int k = 0; k < 8; k++) exp_bus.push_back({base + 64'(k), tag});
  endtask

  task automatic wait_rsp(input int i, input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (rsp_cnt[i] >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rsp_timeout", 192'(ok), 192'(1));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 192'({c_reqack, c_respcyc, c_resp, c_resptag, m_reqcyc, m_req, m_reqtag, m_respack}), 192'(0));
  endtask

  task automatic phase_end(input int ra0, input int ra1, input int rp);
    repeat (4) @(negedge clk);
    check("bus_queue_drained", 192'(exp_bus.size()), 192'(0));
    check("resp_queues_drained", 192'(exp_resp[0].size() + exp_resp[1].size()), 192'(0));
    check("reqack_icache_count", 192'(n_reqack[0] - ra0), 192'(0));
    check("reqack_dcache_count", 192'(n_reqack[1] - ra1), 192'(0));
    check("respack_count", 192'(n_respack - rp), 192'(0));
  endtask

  int a0, a1, rp;

  initial begin
    reset = 1'b1;
    tb_cyc[0] = 1'b0; tb_cyc[1] = 1'b0;
    c_req[0] = '0; c_req[1] = '0; c_reqtag[0] = '0; c_reqtag[1] = '0;
    c_respack = '0; m_reqack = 1'b0; m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0; n_reqack[0] = 0; n_reqack[1] = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset = 1'b0;

    // icache line fill of 0x1000
    a0 = n_reqack[0] + 1; a1 = n_reqack[1]; rp = n_respack + 8;
    push_read(0, 64'h1000, 13'h1005);
    client_read(0, 64'h1000, 13'h1005);
    wait_rsp(0, 8);
    phase_end(a0, a1, rp);

    // dcache writeback of 0x2040, data 0xA0..0xA7
    a0 = n_reqack[0]; a1 = n_reqack[1] + 9; rp = n_respack;
    push_write(64'h2040, 13'h0021, 64'hA0);
    client_write(1, 64'h2040, 13'h0021, 64'hA0, 99);
    phase_end(a0, a1, rp);

    // simultaneous requests, then icache alone, then simultaneous again
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    a0 = n_reqack[0] + 3; a1 = n_reqack[1] + 2; rp = n_respack + 40;
`ifdef ARB_DCACHE_PRIORITY_EN
    push_read(1, 64'h4000, 13'h1002);
    push_read(0, 64'h3000, 13'h1001);
`else
    push_read(0, 64'h3000, 13'h1001);
    push_read(1, 64'h4000, 13'h1002);
`endif
    fork
      client_read(0, 64'h3000, 13'h1001);
      client_read(1, 64'h4000, 13'h1002);
    join
    wait_rsp(0, 8); wait_rsp(1, 8);
    repeat (3) @(negedge clk);
    push_read(0, 64'h5000, 13'h1004);
    client_read(0, 64'h5000, 13'h1004);
    wait_rsp(0, 16);
    repeat (3) @(negedge clk);
    push_read(1, 64'h7000, 13'h1007);
    push_read(0, 64'h6000, 13'h1006);
    fork
      client_read(0, 64'h6000, 13'h1006);
      client_read(1, 64'h7000, 13'h1007);
    join
    wait_rsp(0, 24); wait_rsp(1, 16);
    phase_end(a0, a1, rp);

    // icache withholds respack for 5 cycles on beat 3
    rsp_cnt[0] = 0;
    hold_idx = 0; hold_beat = 3; hold_left = 5;
    a0 = n_reqack[0] + 1; a1 = n_reqack[1]; rp = n_respack + 8;
    push_read(0, 64'h8000, 13'h1003);
    client_read(0, 64'h8000, 13'h1003);
    wait_rsp(0, 8);
    check("hold_consumed", 192'(hold_left), 192'(0));
    phase_end(a0, a1, rp);

    // reset in the middle of a read, then a fresh read
    rsp_cnt[0] = 0;
    push_read(0, 64'h9000, 13'h1009);
    client_read(0, 64'h9000, 13'h1009);
    wait_rsp(0, 4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("midread_reset_outputs");
    exp_resp[0].delete();
    rsp_cnt[0] = 0;
    repeat (2) @(negedge clk);
    check_outputs_zero("midread_reset_held");
    reset = 1'b0;
    a0 = n_reqack[0] + 1; a1 = n_reqack[1]; rp = n_respack + 8;
    push_read(0, 64'hA000, 13'h100A);
    client_read(0, 64'hA000, 13'h100A);
    wait_rsp(0, 8);
    phase_end(a0, a1, rp);

    // dcache write stalled for 3 cycles before beat 2
    a0 = n_reqack[0]; a1 = n_reqack[1] + 9; rp = n_respack;
    push_write(64'hB000, 13'h0042, 64'hB0);
    client_write(1, 64'hB000, 13'h0042, 64'hB0, 2);
    phase_end(a0, a1, rp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the L1 instruction and data caches.
- Merges their line-fill and line-writeback transactions onto the single system memory bus.
- Grants one client at a time and holds the grant for the whole 8-beat line transaction.
- Steers response beats back to the owning cache, and passes write-data beats from the owning cache onto the bus.

Parameters:
- WORDSIZE, 64, width of address/data word.
- TAGWIDTH, 13, width of reqtag/resptag; bit TAGWIDTH-1 = 1 read, 0 write.
- BEATS, 8, words per cache line (one fill or writeback).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- c_reqcyc[2]  in  2 x 1  per-client request valid; index 0 = icache, 1 = dcache.
- c_req[2]  in  2 x WORDSIZE  line address on header; write data on subsequent beats.
- c_reqtag[2]  in  2 x TAGWIDTH  request tag.
- c_reqack[2]  out  2 x 1  one-cycle acceptance pulse per header/beat.
- c_respcyc[2]  out  2 x 1  response beat valid.
- c_resp  out  WORDSIZE  response data; shared by both clients, qualified by c_respcyc.
- c_resptag  out  TAGWIDTH  response tag.
- c_respack[2]  in  2 x 1  client accepts response beat.
- m_reqcyc  out  1  bus request valid.
- m_req  out  WORDSIZE  bus address/data.
- m_reqtag  out  TAGWIDTH  bus tag.
- m_reqack  in  1  bus accepts header/beat.
- m_respcyc  in  1  bus response beat valid.
- m_resp  in  WORDSIZE  bus response data.
- m_resptag  in  TAGWIDTH  bus response tag.
- m_respack  out  1  response beat acknowledge.

Behaviour:
- Reset: all outputs 0; state IDLE; owner=0; rr_last=1 (so icache wins the first tie); beat=0.
- States: IDLE, REQ, RD_BEATS, WR_BEATS, DONE.
- IDLE:
  - Pick owner among asserted c_reqcyc; round-robin tie-break (grant the client not in rr_last).
  - Register c_req/c_reqtag into m_req/m_reqtag; assert m_reqcyc; go to REQ.
  - Grant decision to m_reqcyc high takes 1 cycle.
- REQ:
  - Hold m_reqcyc until m_reqack.
  - On m_reqack: pulse c_reqack[owner] for 1 cycle; drop m_reqcyc.
  - Then go to RD_BEATS if tag MSB=1, else WR_BEATS; beat=0.
- RD_BEATS:
  - Each m_respcyc beat: forward m_resp/m_resptag to c_resp/c_resptag; c_respcyc[owner]=1 the next cycle.
  - Hold c_respcyc[owner] until c_respack[owner]; then pulse m_respack for 1 cycle; beat++.
  - m_respcyc ignored while a forwarded beat is unacked (no overwrite).
  - After beat 7 is acked: go to DONE.
- WR_BEATS:
  - While c_reqcyc[owner]: drive m_req=c_req[owner] data and m_reqcyc=1.
  - On m_reqack: pulse c_reqack[owner]; beat++.
  - After 8th ack: go to DONE.
  - No bus response expected.
- DONE: deassert all; rr_last=owner; go to IDLE next cycle. Minimum one idle cycle between transactions.
- Non-owner:
  - c_reqack and c_respcyc held 0; its request stays pending with no timeout.
- Boundaries:
  - Both clients request in the same cycle: the non-rr_last client wins.
  - Owner drops c_reqcyc mid-write: stall; no beat is counted.
  - Beat counter width log2(BEATS)+1; no wrap.
  - Async reset mid-transaction aborts immediately: all outputs 0 and no partial state kept. Caches must also be reset.
  - Beat-7 respack and a new request in the same cycle: the new request is not sampled until IDLE.

Optional Feature:
- ARB_DCACHE_PRIORITY_EN.
- Defined: fixed priority; dcache wins every tie; rr_last unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package mem_bus_pkg holds:
  - arb_state_t enum.
  - Client index constants ICACHE=0, DCACHE=1.
  - TAG_READ_BIT.
  - BEATS_PER_LINE=8.
- One sub-module, arb_rr_picker: combinational 2-way grant from reqcyc[2] and rr_last, with the priority macro applied inside.

Test Plan:
- icache read of 0x1000 alone -> m_req=0x1000, tag MSB=1; 8 bus beats 0..7 arrive at c_resp in order with c_respcyc[0] only; beat count 8, then IDLE.
- dcache write of 0x2040, data 0xA0..0xA7 -> header then 8 m_req data beats matching the data; 9 c_reqack[1] pulses; no m_respack.
- Both request at cycle 0 after reset -> icache granted first, dcache next; repeat with both -> alternates (with ARB_DCACHE_PRIORITY_EN: dcache always first).
- Owner withholds c_respack for 5 cycles on beat 3 -> c_resp stable; m_respack stays 0; no beat lost or duplicated.
- Reset asserted during RD_BEATS beat 4 -> all outputs 0 same cycle; next request served fresh from beat 0.
- Owner drops c_reqcyc for 3 cycles during write beat 2 -> m_reqcyc drops; write resumes with beat 2 data; still exactly 8 data beats.
